keccak_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `keccak` hash core between NREQ requesters in the ROLLO decrypt datapath. It grants the core to one requester at a time and issues the start pulse. It steers the core's read-only memory port to the owner's message memory, then captures the 512-bit digest and returns it with a per-requester done pulse.

---
 rtl/keccak_arbiter.sv | 140 ++++++++++++++
 tb/tb_keccak_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one keccak core between NREQ requesters:
// grants, starts the core, steers its memory port and returns the digest.
module keccak_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 7,
    parameter int unsigned DW   = 67
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [511:0]       digest,
    output logic               busy,
    output logic               err,
    output logic               k_in_ready,
    input  logic [AW-1:0]      k_mem_addr,
    input  logic               k_mem_rw,
    output logic [DW-1:0]      k_mem_din,
    input  logic [511:0]       k_out,
    input  logic               k_out_ready,
    output logic [NREQ*AW-1:0] req_mem_addr,
    input  logic [NREQ*DW-1:0] req_mem_din
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StRel} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [511:0]      digest_q, digest_d;
    logic              err_q, err_d;
    logic              kir_q, kir_d;

    logic              found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    int unsigned       idx;

    // First set request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        done_d   = '0;
        kir_d    = 1'b0;
        digest_d = digest_q;
        err_d    = err_q;
        if (k_mem_rw) err_d = 1'b1;
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);
                    kir_d          = 1'b1;
                    state_d        = StStart;
                end
            end
            StStart: begin
                if (k_out_ready) err_d = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (k_out_ready) begin
                    digest_d = k_out;
                    done_d   = gnt_q;
                    state_d  = StRel;
                end
            end
            StRel: begin
                if (k_out_ready) err_d = 1'b1;
                if ((req & gnt_q) == '0) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            ptr_q    <= '0;
            done_q   <= '0;
            kir_q    <= 1'b0;
            digest_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
            kir_q    <= kir_d;
            digest_q <= digest_d;
            err_q    <= err_d;
        end
    end

    // gnt is one-hot or zero, so OR-ing the gated slices is a clean mux.
    always_comb begin
        req_mem_addr = '0;
        k_mem_din    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_q[i]) begin
                req_mem_addr[i*AW +: AW] = k_mem_addr;
                k_mem_din                = k_mem_din | req_mem_din[i*DW +: DW];
            end
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign digest     = digest_q;
    assign busy       = (state_q != StIdle);
    assign err        = err_q;
    assign k_in_ready = kir_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed self-checking bench for keccak_arbiter with NREQ=2, AW=7, DW=67.
module tb_keccak_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 7;
    localparam int unsigned DW   = 67;

    logic               clk;
    logic               rst_b;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [511:0]       digest;
    logic               busy;
    logic               err;
    logic               k_in_ready;
    logic [AW-1:0]      k_mem_addr;
    logic               k_mem_rw;
    logic [DW-1:0]      k_mem_din;
    logic [511:0]       k_out;
    logic               k_out_ready;
    logic [NREQ*AW-1:0] req_mem_addr;
    logic [NREQ*DW-1:0] req_mem_din;

    int n_checks = 0;
    int n_bad    = 0;

    keccak_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req          (req),
        .gnt          (gnt),
        .done         (done),
        .digest       (digest),
        .busy         (busy),
        .err          (err),
        .k_in_ready   (k_in_ready),
        .k_mem_addr   (k_mem_addr),
        .k_mem_rw     (k_mem_rw),
        .k_mem_din    (k_mem_din),
        .k_out        (k_out),
        .k_out_ready  (k_out_ready),
        .req_mem_addr (req_mem_addr),
        .req_mem_din  (req_mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in WAIT: pulse the core result, check capture, drop the owner's request.
    task automatic complete(input logic [1:0] own, input logic [511:0] val, input string tag);
        k_out       = val;
        k_out_ready = 1'b1;
        step();
        k_out_ready = 1'b0;
        k_out       = '0;
        check_eq({tag, "_done"}, 512'(done), 512'(own));
        check_eq({tag, "_digest"}, digest, val);
        check_eq({tag, "_rel_busy"}, 512'(busy), 512'(1'b1));
        req = req & ~own;
        step();
        check_eq({tag, "_gnt_free"}, 512'(gnt), 512'(2'b00));
        check_eq({tag, "_busy_free"}, 512'(busy), 512'(1'b0));
        check_eq({tag, "_done_clr"}, 512'(done), 512'(2'b00));
    endtask

    int           pulses;
    int           e;
    logic [1:0]   own;
    logic [511:0] v;

    initial begin
        rst_b       = 1'b0;
        req         = '0;
        k_mem_addr  = 7'h05;
        k_mem_rw    = 1'b0;
        k_out       = '0;
        k_out_ready = 1'b0;
        req_mem_din = {67'h1234, 67'h7FF};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_gnt", 512'(gnt), 512'(2'b00));
        check_eq("rst_busy", 512'(busy), 512'(1'b0));
        check_eq("rst_done", 512'(done), 512'(2'b00));
        check_eq("rst_kir", 512'(k_in_ready), 512'(1'b0));
        check_eq("rst_err", 512'(err), 512'(1'b0));
        check_eq("rst_digest", digest, 512'(0));
        check_eq("rst_addr", 512'(req_mem_addr), 512'(0));
        check_eq("rst_din", 512'(k_mem_din), 512'(0));
        @(negedge clk);
        rst_b = 1'b1;
        step();

        // Single request from requester 0
        req = 2'b01;
        step();
        check_eq("single_gnt", 512'(gnt), 512'(2'b01));
        check_eq("single_busy", 512'(busy), 512'(1'b1));
        check_eq("single_kir", 512'(k_in_ready), 512'(1'b1));
        step();
        check_eq("single_kir_once", 512'(k_in_ready), 512'(1'b0));
        pulses = 0;
        repeat (28) begin
            step();
            pulses += int'(k_in_ready) + int'(|done);
        end
        check_eq("single_no_extra", 512'(pulses), 512'(0));
        complete(2'b01, {64{8'hA5}}, "single");

        // Memory steering with requester 1 as owner
        req = 2'b10;
        step();
        check_eq("steer_gnt", 512'(gnt), 512'(2'b10));
        check_eq("steer_din", 512'(k_mem_din), 512'(67'h1234));
        check_eq("steer_addr", 512'(req_mem_addr), 512'({7'h05, 7'h00}));
        step();
        complete(2'b10, {16{32'hB0B0_0001}}, "steer");
        check_eq("free_din", 512'(k_mem_din), 512'(0));
        check_eq("free_addr", 512'(req_mem_addr), 512'(0));

        // Contention: both held, each re-raises one cycle after its release
        req = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            e   = k % 2;
            own = (e == 0) ? 2'b01 : 2'b10;
            v   = {16{32'hC0DE_0000 + 32'(k)}};
            check_eq("fair_gnt", 512'(gnt), 512'(own));
            check_eq("fair_kir", 512'(k_in_ready), 512'(1'b1));
            check_eq("fair_din", 512'(k_mem_din), (e == 0) ? 512'(67'h7FF) : 512'(67'h1234));
            check_eq("fair_addr", 512'(req_mem_addr),
                     (e == 0) ? 512'({7'h00, 7'h05}) : 512'({7'h05, 7'h00}));
            step();
            check_eq("fair_kir_once", 512'(k_in_ready), 512'(1'b0));
            complete(own, v, "fair");
            if (k < 3) begin
                req = req | own;
                step();
            end else begin
                req = '0;
            end
        end

        // Request dropped mid-hash
        req = 2'b01;
        step();
        check_eq("drop_gnt", 512'(gnt), 512'(2'b01));
        step();
        step();
        req = 2'b00;
        step();
        check_eq("drop_busy", 512'(busy), 512'(1'b1));
        check_eq("drop_gnt_held", 512'(gnt), 512'(2'b01));
        complete(2'b01, {64{8'h3C}}, "drop");

        // Stray result while idle: ignored, no error
        k_out       = {64{8'hFF}};
        k_out_ready = 1'b1;
        step();
        k_out_ready = 1'b0;
        k_out       = '0;
        check_eq("stray_done", 512'(done), 512'(2'b00));
        check_eq("stray_digest", digest, {64{8'h3C}});
        check_eq("stray_err", 512'(err), 512'(1'b0));
        check_eq("stray_busy", 512'(busy), 512'(1'b0));

        // Memory write attempt while busy sets sticky err (ptr ends at 1)
        req = 2'b01;
        step();
        check_eq("err_gnt", 512'(gnt), 512'(2'b01));
        step();
        k_mem_rw = 1'b1;
        step();
        k_mem_rw = 1'b0;
        check_eq("err_set", 512'(err), 512'(1'b1));
        step();
        step();
        check_eq("err_sticky", 512'(err), 512'(1'b1));

        // Asynchronous reset mid-hash
        #2;
        rst_b = 1'b0;
        #1;
        check_eq("amid_gnt", 512'(gnt), 512'(2'b00));
        check_eq("amid_busy", 512'(busy), 512'(1'b0));
        check_eq("amid_done", 512'(done), 512'(2'b00));
        check_eq("amid_err", 512'(err), 512'(1'b0));
        check_eq("amid_kir", 512'(k_in_ready), 512'(1'b0));
        check_eq("amid_digest", digest, 512'(0));
        @(negedge clk);
        rst_b = 1'b1;
        req   = 2'b11;
        step();
        check_eq("post_rst_ptr", 512'(gnt), 512'(2'b01));
        step();
        complete(2'b01, {16{32'h0123_4567}}, "post0");
        req = 2'b10;
        step();
        check_eq("post_rst_gnt1", 512'(gnt), 512'(2'b10));
        check_eq("post_rst_kir1", 512'(k_in_ready), 512'(1'b1));
        step();
        complete(2'b10, {16{32'h89AB_CDEF}}, "post1");
        check_eq("post_rst_err", 512'(err), 512'(1'b0));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
